uart_rx_latch: RTL and testbench

- UART receiver: the receive-side counterpart of the system's sum/latch UART transmit path.
- Samples an asynchronous serial line (8N1, LSB first), rebuilds each byte and holds it in an output register.
- The held byte is presented with a valid/ack handshake, plus framing-error and overrun flags.
- Sits between the chip input pad and the operand latch logic, so operands can arrive over serial instead of parallel switches.

---
 rtl/uart_rx_latch.sv | 144 ++++++++++++++
 tb/tb_uart_rx_latch.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_latch.sv
// 8N1 UART receiver: synchronizes rx, rebuilds LSB-first frames and holds each
// good byte in an output register behind a valid/ack handshake with sticky error flags.
module uart_rx_latch #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    input  logic                 data_ack,
    output logic                 frame_err,
    output logic                 overrun,
    input  logic                 err_clr,
    output logic                 busy
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int IDX_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

    state_t               state, state_n;
    logic [CNT_W-1:0]     cnt, cnt_n;
    logic [IDX_W-1:0]     idx, idx_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic                 byte_done, done_n;
    logic                 fe_set;
    logic                 ovr_set;
    logic                 sync_1, rx_s;
    logic [1:0]           warm;

    // warm tracks how many real samples have entered the synchronizer since reset,
    // so the reset value of rx_s is never mistaken for a released (high) line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            idx       <= '0;
            shreg     <= '0;
            byte_done <= 1'b0;
            sync_1    <= 1'b1;
            rx_s      <= 1'b1;
            warm      <= '0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            shreg     <= shreg_n;
            byte_done <= done_n;
            sync_1    <= rx;
            rx_s      <= sync_1;
            warm      <= {warm[0], 1'b1};
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        shreg_n = shreg;
        done_n  = 1'b0;
        fe_set  = 1'b0;
        case (state)
            IDLE: begin
                if (!warm[0]) begin
                    state_n = BREAK;
                end else if (!rx_s) begin
                    cnt_n   = '0;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    if (!rx_s) begin
                        cnt_n   = '0;
                        idx_n   = '0;
                        state_n = DATA;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_n          = '0;
                    shreg_n[idx]   = rx_s;
                    if (idx == IDX_LAST) state_n = STOP;
                    else                 idx_n   = idx + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        done_n  = 1'b1;
                        state_n = IDLE;
                    end else begin
                        fe_set  = 1'b1;
                        state_n = BREAK;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            BREAK: begin
                if (rx_s && warm[1]) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    assign ovr_set = byte_done && data_valid && !data_ack;

    // A coincident ack frees the holding register, so the new byte loads instead of overrunning.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (byte_done && (!data_valid || data_ack)) begin
                data_out   <= shreg;
                data_valid <= 1'b1;
            end else if (data_ack) begin
                data_valid <= 1'b0;
            end
            frame_err <= fe_set  | (frame_err & ~err_clr);
            overrun   <= ovr_set | (overrun   & ~err_clr);
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx_latch.sv
// Directed bench for uart_rx_latch at 8 clocks per bit: framing, latency,
// handshake, glitch rejection, framing error, overrun, back-to-back and reset recovery.
module tb_uart_rx_latch;

    localparam int CPB = 8;

    logic       clk;
    logic       rst_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       data_ack;
    logic       frame_err;
    logic       overrun;
    logic       err_clr;
    logic       busy;

    int checks = 0;
    int errors = 0;

    uart_rx_latch #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .data_out   (data_out),
        .data_valid (data_valid),
        .data_ack   (data_ack),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .err_clr    (err_clr),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic send_bit(input logic b);
        rx = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_payload(input logic [7:0] d);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_payload(d);
        send_bit(stop);
    endtask

    task automatic pulse_ack_clr(input logic ack, input logic clr);
        data_ack = ack;
        err_clr  = clr;
        @(posedge clk);
        #1;
        data_ack = 1'b0;
        err_clr  = 1'b0;
    endtask

    task automatic test_reset();
        rx = 1'b1; data_ack = 1'b0; err_clr = 1'b0;
        rst_n = 1'b1;
        #3 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({data_out, data_valid, frame_err, overrun, busy} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL reset_outputs got %h expected 000", {data_out, data_valid, frame_err, overrun, busy});
        end
        rst_n = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_busy got %b expected 0", busy);
        end
    endtask

    task automatic test_basic();
        send_payload(8'hA5);
        rx = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_early_valid got %b expected 0", data_valid);
        end
        @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL basic_latency got valid=%b data=%h expected valid=1 data=a5", data_valid, data_out);
        end
        checks++;
        if (frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_flags got fe=%b ovr=%b expected 0 0", frame_err, overrun);
        end
        repeat (50) @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'hA5) begin
            errors++;
            $display("[TB] FAIL basic_hold got valid=%b data=%h expected valid=1 data=a5", data_valid, data_out);
        end
        pulse_ack_clr(1'b1, 1'b0);
        checks++;
        if (data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL basic_ack got %b expected 0", data_valid);
        end
    endtask

    task automatic test_glitch();
        rx = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL glitch_busy_rise got %b expected 1", busy);
        end
        repeat (12) @(posedge clk);
        #1;
        checks++;
        if ({busy, data_valid, frame_err, overrun} !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL glitch_quiet got %b expected 0000", {busy, data_valid, frame_err, overrun});
        end
    endtask

    task automatic test_framing();
        int waited;
        send_frame(8'h3C, 1'b0);
        repeat (40) @(posedge clk);
        #1;
        checks++;
        if (frame_err !== 1'b1 || data_valid !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("[TB] FAIL frame_break got fe=%b valid=%b busy=%b expected 1 0 1", frame_err, data_valid, busy);
        end
        rx = 1'b1;
        waited = 0;
        while (busy === 1'b1 && waited < 10) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_release got busy=%b expected 0", busy);
        end
        pulse_ack_clr(1'b0, 1'b1);
        checks++;
        if (frame_err !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL frame_clear got fe=%b valid=%b expected 0 0", frame_err, data_valid);
        end
    endtask

    task automatic test_overrun();
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        checks++;
        if (data_out !== 8'h11 || overrun !== 1'b1 || data_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_set got data=%h ovr=%b valid=%b expected 11 1 1", data_out, overrun, data_valid);
        end
        pulse_ack_clr(1'b1, 1'b1);
        checks++;
        if (overrun !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL overrun_clear got ovr=%b valid=%b expected 0 0", overrun, data_valid);
        end
        send_frame(8'h11, 1'b1);
        send_payload(8'h22);
        rx = 1'b1;
        repeat (7) @(posedge clk);
        #1;
        pulse_ack_clr(1'b1, 1'b0);
        checks++;
        if (data_out !== 8'h22 || overrun !== 1'b0 || data_valid !== 1'b1) begin
            errors++;
            $display("[TB] FAIL overrun_ack_wins got data=%h ovr=%b valid=%b expected 22 0 1", data_out, overrun, data_valid);
        end
        pulse_ack_clr(1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_b [3];
        int got;
        exp_b[0] = 8'h00; exp_b[1] = 8'hFF; exp_b[2] = 8'h55;
        got = 0;
        fork
            begin
                send_frame(8'h00, 1'b1);
                send_frame(8'hFF, 1'b1);
                send_frame(8'h55, 1'b1);
            end
            begin
                for (int c = 0; c < 300 && got < 3; c++) begin
                    @(negedge clk);
                    if (data_valid === 1'b1) begin
                        checks++;
                        if (data_out !== exp_b[got]) begin
                            errors++;
                            $display("[TB] FAIL b2b_byte%0d got %h expected %h", got, data_out, exp_b[got]);
                        end
                        got++;
                        data_ack = 1'b1;
                        @(negedge clk);
                        data_ack = 1'b0;
                    end
                end
            end
        join
        @(posedge clk);
        #1;
        checks++;
        if (got !== 3 || frame_err !== 1'b0 || overrun !== 1'b0) begin
            errors++;
            $display("[TB] FAIL b2b_count got %0d fe=%b ovr=%b expected 3 0 0", got, frame_err, overrun);
        end
    endtask

    task automatic test_reset_mid();
        send_frame(8'h3C, 1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({data_out, data_valid, frame_err, overrun, busy} !== 12'h000) begin
            errors++;
            $display("[TB] FAIL midreset_outputs got %h expected 000", {data_out, data_valid, frame_err, overrun, busy});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checks++;
        if (data_valid !== 1'b0 || busy !== 1'b1 || frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_low_line got valid=%b busy=%b fe=%b expected 0 1 0", data_valid, busy, frame_err);
        end
        rx = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || data_valid !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_release got busy=%b valid=%b expected 0 0", busy, data_valid);
        end
        send_frame(8'h81, 1'b1);
        checks++;
        if (data_valid !== 1'b1 || data_out !== 8'h81 || frame_err !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midreset_new_frame got valid=%b data=%h fe=%b expected 1 81 0", data_valid, data_out, frame_err);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL timeout got running expected finished");
        $fatal(1, "[TB] timeout");
    end

endmodule
